bitserial_modadd_ctrl: RTL and testbench

- Controller that time-multiplexes a single one-bit full-adder cell to compute the ML-KEM coefficient addition (a + b) mod Q.
- Operands are processed LSB-first:
  - ADD phase: a + b into a (W+1)-bit sum.
  - SUB phase: sum − Q, using the same cell with inverted Q bits and carry-in 1.
  - Selection of the final result by the SUB carry-out.
- Sits between the coefficient buffer and the NTT butterfly stage as a low-area modular adder with valid/ready handshakes on both sides.

---
 rtl/bitserial_modadd_ctrl.sv | 157 +++++++++++++++
 tb/tb_bitserial_modadd_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_modadd_ctrl.sv
// Bit-serial (a + b) mod Q built around one full-adder cell, LSB first.
// The ADD phase forms a W+1 bit sum; the SUB phase forms sum - Q; the SUB carry-out picks the result.
module bitserial_modadd_ctrl #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and the result
  // holds steady in DONE until it is taken.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int             CW          = $clog2(W + 1);
  localparam logic [CW-1:0]  LP_ADD_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  LP_SUB_LAST = CW'(W);
  localparam logic [CW-1:0]  LP_CNT_ONE  = CW'(1);
  localparam logic [W:0]     LP_QX       = (W + 1)'(Q);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W:0]    r_sum;
  logic [W-1:0]  r_diff;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_busy;

  logic          w_x;
  logic          w_y;
  logic          w_s;
  logic          w_co;

  // Operand steering for the shared cell; SUB adds ~Q with carry-in 1.
  always_comb begin
    w_x = 1'b0;
    w_y = 1'b0;
    case (r_state)
      S_ADD: begin
        w_x = r_a[0];
        w_y = r_b[0];
      end
      S_SUB: begin
        w_x = r_sum[r_cnt];
        w_y = ~LP_QX[r_cnt];
      end
      default: begin
        w_x = 1'b0;
        w_y = 1'b0;
      end
    endcase
  end

  assign w_s  = w_x ^ w_y ^ r_carry;
  assign w_co = (w_x & w_y) | (r_carry & (w_x ^ w_y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_diff      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_sum      <= '0;
            r_diff     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ADD;
          end
        end

        S_ADD: begin
          r_sum[r_cnt] <= w_s;
          r_a          <= r_a >> 1;
          r_b          <= r_b >> 1;
          if (r_cnt == LP_ADD_LAST) begin
            r_sum[W] <= w_co;
            r_carry  <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_SUB;
          end else begin
            r_carry <= w_co;
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end

        S_SUB: begin
          r_carry <= w_co;
          if (r_cnt == LP_SUB_LAST) begin
            // Final carry set means sum >= Q, so the difference is the answer.
            r_out_data  <= w_co ? r_diff : r_sum[W-1:0];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_diff[r_cnt] <= w_s;
            r_cnt         <= r_cnt + LP_CNT_ONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bitserial_modadd_ctrl.sv
// Directed and back-to-back checks for the bit-serial modular adder controller.
module tb_bitserial_modadd_ctrl;

  localparam int W = 12;
  localparam int Q = 3329;
  localparam int LAT = 2 * W + 1;
  localparam int GAP = 2 * W + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_total;
  int n_bad;
  int cyc;
  logic [W-1:0] exp_q[$];

  bitserial_modadd_ctrl #(.W(W), .Q(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp_v);
    n_total++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // Driver: one operation with latency and busy-width checks.
  task automatic run_op(input int a, input int b, input int exp_v, input string tag);
    int lat;
    int busy_cnt;
    int waited;
    logic [W-1:0] e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready_before"}, int'(in_ready), 1);
    in_a     = W'(a);
    in_b     = W'(b);
    in_valid = 1'b1;
    exp_q.push_back(W'(exp_v));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_ready_after_accept"}, int'(in_ready), 0);
    busy_cnt = int'(busy);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_busy_cycles"}, busy_cnt, LAT);
    e = exp_q.pop_front();
    chk({tag, "_data"}, int'(out_data), int'(e));
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, int'(out_valid), 0);
      chk({tag, "_ready_back"}, int'(in_ready), 1);
    end
  endtask

  task automatic back_to_back(input int n_ops);
    int acc_cnt;
    int res_cnt;
    int last_acc;
    int budget;
    logic [W-1:0] e;
    acc_cnt  = 0;
    res_cnt  = 0;
    last_acc = 0;
    budget   = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_a     = W'($urandom_range(0, Q - 1));
    in_b     = W'($urandom_range(0, Q - 1));
    in_valid = 1'b1;
    while (res_cnt < n_ops && budget < n_ops * GAP + 200) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("b2b_data", int'(out_data), int'(e));
        res_cnt++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(W'((int'(in_a) + int'(in_b)) % Q));
        if (acc_cnt > 0) chk("b2b_spacing", cyc - last_acc, GAP);
        last_acc = cyc;
        acc_cnt++;
      end else begin
        if (acc_cnt >= n_ops) in_valid = 1'b0;
        in_a = W'($urandom_range(0, Q - 1));
        in_b = W'($urandom_range(0, Q - 1));
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    chk("b2b_results", res_cnt, n_ops);
    chk("b2b_accepts", acc_cnt, n_ops);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(dbg_state), 0);

    run_op(100, 200, 300, "basic");
    run_op(3328, 1, 0, "wrap_a");
    run_op(1664, 1665, 0, "wrap_b");
    run_op(3328, 3328, 3327, "max");
    run_op(0, 0, 0, "zero");
    run_op(3000, 328, 3328, "q_minus_1");
    run_op(4095, 4095, 765, "out_of_range");

    // Backpressure: hold result in DONE, poke in_valid, confirm nothing moves.
    out_ready = 1'b0;
    run_op(1000, 2000, 3000, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a     = 12'd55;
      in_b     = 12'd66;
      chk("bp_valid_hold", int'(out_valid), 1);
      chk("bp_data_hold", int'(out_data), 3000);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_state", int'(dbg_state), 3);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_busy", int'(busy), 0);

    // Asynchronous reset in the middle of the ADD phase.
    @(negedge clk);
    in_a     = 12'd500;
    in_b     = 12'd600;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_data", int'(out_data), 0);
    run_op(7, 8, 15, "after_rst");

    back_to_back(200);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
